cv32e40p_clock_en_ctrl: RTL and testbench

//  Sequential controller that computes the enable for the core clock gate (drives en_i of cv32e40p_clock_gate).

---
 rtl/cv32e40p_clock_en_ctrl.sv | 103 ++++++++++
 tb/tb_cv32e40p_clock_en_ctrl.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_clock_en_ctrl.sv
// Core clock-enable controller.
// Produces the registered enable for the core clock gate. The core clock stays
// stopped until the first fetch enable and then runs. After a sleep request the
// controller waits for the pipeline to go idle for IDLE_CYCLES consecutive
// cycles, stops the clock, and restarts it on wake. It also counts the cycles
// spent asleep, saturating at all-ones.
// This block must run on the free-running (ungated) clock.
module cv32e40p_clock_en_ctrl #(
   parameter int IDLE_CYCLES = 2,
   parameter int CNT_W       = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             fetch_enable_i,
   input  logic             sleep_req_i,
   input  logic             core_busy_i,
   input  logic             wake_i,
   output logic             clock_en_o,
   output logic             core_sleep_o,
   output logic [CNT_W-1:0] sleep_cnt_o
);

   // Wide enough to hold IDLE_CYCLES, and never narrower than one bit.
   localparam int IDLE_W = (IDLE_CYCLES < 1) ? 1 : $clog2(IDLE_CYCLES + 1);
   localparam logic [IDLE_W-1:0] IDLE_LOAD = IDLE_W'(IDLE_CYCLES);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      SLEEP = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [IDLE_W-1:0] idle_q, idle_d;
   logic              clock_en_d;
   logic              core_sleep_d;

   // Next-state logic, the idle countdown, and the next output values.
   // Outputs are computed from the next state so that the flops present them
   // in the cycle right after the state is entered.
   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      case (state_q)
         BOOT: begin
            // Only fetch enable matters here; other inputs may still be undefined.
            if (fetch_enable_i) state_d = RUN;
         end
         RUN: begin
            // A pending wake cancels the sleep request.
            if (sleep_req_i && !wake_i) begin
               state_d = DRAIN;
               idle_d  = IDLE_LOAD;
            end
         end
         DRAIN: begin
            // Wake aborts. Busy restarts the idle window. Otherwise count down.
            if (wake_i) begin
               state_d = RUN;
            end else if (core_busy_i) begin
               idle_d = IDLE_LOAD;
            end else if (idle_q == '0) begin
               state_d = SLEEP;
            end else begin
               idle_d = idle_q - IDLE_W'(1);
            end
         end
         SLEEP: begin
            if (wake_i) state_d = RUN;
         end
         default: state_d = BOOT;
      endcase
      clock_en_d   = (state_d == RUN) || (state_d == DRAIN);
      core_sleep_d = (state_d == SLEEP);
   end

   // State register, idle counter and registered outputs.
   // Reset forces the clock off immediately.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= BOOT;
         idle_q       <= '0;
         clock_en_o   <= 1'b0;
         core_sleep_o <= 1'b0;
      end else begin
         state_q      <= state_d;
         idle_q       <= idle_d;
         clock_en_o   <= clock_en_d;
         core_sleep_o <= core_sleep_d;
      end
   end

   // Counts edges taken while asleep and holds at all-ones instead of wrapping.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sleep_cnt_o <= '0;
      end else if ((state_q == SLEEP) && (sleep_cnt_o != '1)) begin
         sleep_cnt_o <= sleep_cnt_o + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_cv32e40p_clock_en_ctrl.sv
// Bench for cv32e40p_clock_en_ctrl.
// The main instance uses IDLE_CYCLES=2 and CNT_W=4. A second instance uses
// IDLE_CYCLES=0 and CNT_W=8 to cover the one-cycle drain.
// Input changes happen on the falling edge. Expected {en, sleep, cnt} values go
// into a queue when stimulus is driven, and are popped and compared 1ns after
// the next rising edge.
module tb_cv32e40p_clock_en_ctrl;

   logic       clk;
   logic       rst_n;
   logic       fe, sr, bz, wk;
   logic       en, sl;
   logic [3:0] cnt;
   logic       fe0, sr0, bz0, wk0;
   logic       en0, sl0;
   logic [7:0] cnt0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [5:0] exp_q[$];
   logic [9:0] exp0_q[$];

   typedef struct {
      logic       fe, sr, bz, wk;
      logic       en, sl;
      logic [3:0] cnt;
   } vec_t;
   vec_t vec_q[$];

   cv32e40p_clock_en_ctrl #(.IDLE_CYCLES(2), .CNT_W(4)) u_dut (
      .clk_i(clk), .rst_ni(rst_n), .fetch_enable_i(fe), .sleep_req_i(sr),
      .core_busy_i(bz), .wake_i(wk), .clock_en_o(en), .core_sleep_o(sl),
      .sleep_cnt_o(cnt)
   );

   cv32e40p_clock_en_ctrl #(.IDLE_CYCLES(0), .CNT_W(8)) u_dut0 (
      .clk_i(clk), .rst_ni(rst_n), .fetch_enable_i(fe0), .sleep_req_i(sr0),
      .core_busy_i(bz0), .wake_i(wk0), .clock_en_o(en0), .core_sleep_o(sl0),
      .sleep_cnt_o(cnt0)
   );

   // Clock and reset.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Adds one {inputs, expected outputs} record to the vector table.
   task automatic add(input logic f, input logic s, input logic b, input logic w,
                      input logic e, input logic z, input logic [3:0] c);
      vec_t v;
      v.fe = f; v.sr = s; v.bz = b; v.wk = w; v.en = e; v.sl = z; v.cnt = c;
      vec_q.push_back(v);
   endtask

   // Scoreboard compare for the main instance.
   task automatic check_main(input string name);
      logic [5:0] exp;
      n_checks++;
      if (exp_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, got en=%0b sleep=%0b cnt=%0d", name, en, sl, cnt);
      end else begin
         exp = exp_q.pop_front();
         if ({en, sl, cnt} !== exp) begin
            n_fail++;
            $display("FAIL %s: got en=%0b sleep=%0b cnt=%0d, expected en=%0b sleep=%0b cnt=%0d",
                     name, en, sl, cnt, exp[5], exp[4], exp[3:0]);
         end
      end
   endtask

   // Scoreboard compare for the IDLE_CYCLES=0 instance.
   task automatic check_zero(input string name);
      logic [9:0] exp;
      n_checks++;
      if (exp0_q.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty, got en=%0b sleep=%0b cnt=%0d", name, en0, sl0, cnt0);
      end else begin
         exp = exp0_q.pop_front();
         if ({en0, sl0, cnt0} !== exp) begin
            n_fail++;
            $display("FAIL %s: got en=%0b sleep=%0b cnt=%0d, expected en=%0b sleep=%0b cnt=%0d",
                     name, en0, sl0, cnt0, exp[9], exp[8], exp[7:0]);
         end
      end
   endtask

   // Driver: applies one clock's worth of inputs to the main instance and checks the result.
   task automatic step_main(input vec_t v, input string name);
      @(negedge clk);
      fe = v.fe; sr = v.sr; bz = v.bz; wk = v.wk;
      exp_q.push_back({v.en, v.sl, v.cnt});
      @(posedge clk);
      #1;
      check_main(name);
   endtask

   // Driver: applies one clock's worth of inputs to the IDLE_CYCLES=0 instance and checks the result.
   task automatic step_zero(input logic f, input logic s, input logic b, input logic w,
                            input logic e, input logic z, input logic [7:0] c, input string name);
      @(negedge clk);
      fe0 = f; sr0 = s; bz0 = b; wk0 = w;
      exp0_q.push_back({e, z, c});
      @(posedge clk);
      #1;
      check_zero(name);
   endtask

   initial begin
      vec_t v;
      int   sat;
      rst_n = 1'b0;
      fe = 0; sr = 0; bz = 0; wk = 0;
      fe0 = 0; sr0 = 0; bz0 = 0; wk0 = 0;

      // Build the vector table (main instance, IDLE_CYCLES=2, CNT_W=4).
      // Stay in BOOT: other inputs are active but have no effect.
      for (int i = 0; i < 5; i++) add(0, 1, 1, 1, 0, 0, 0);
      add(1, 0, 0, 0, 1, 0, 0);          // fetch enable -> RUN
      add(0, 0, 0, 0, 1, 0, 0);          // fetch enable dropping is ignored
      add(0, 1, 0, 1, 1, 0, 0);          // sleep and wake together: wake wins
      add(0, 0, 0, 0, 1, 0, 0);
      add(0, 1, 0, 0, 1, 0, 0);          // sleep request -> DRAIN (idle=2)
      add(0, 0, 0, 0, 1, 0, 0);          // idle=1
      add(0, 0, 0, 0, 1, 0, 0);          // idle=0
      add(0, 0, 0, 0, 0, 1, 0);          // -> SLEEP, clock stopped
      // Stay asleep: the sleep request and busy inputs are ignored here.
      for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, 0, 1, 4'(i));
      add(0, 0, 0, 1, 1, 0, 10);         // wake: 10 sleeping edges counted
      add(0, 1, 0, 0, 1, 0, 10);         // DRAIN idle=2
      add(0, 0, 0, 0, 1, 0, 10);         // idle=1
      for (int i = 0; i < 3; i++) add(0, 0, 1, 0, 1, 0, 10); // busy reloads
      add(0, 0, 0, 0, 1, 0, 10);         // idle=1
      add(0, 0, 0, 0, 1, 0, 10);         // idle=0
      add(0, 0, 0, 0, 0, 1, 10);         // 3rd idle edge -> SLEEP
      add(0, 0, 0, 1, 1, 0, 11);         // wake
      add(0, 1, 0, 0, 1, 0, 11);         // DRAIN
      add(0, 0, 0, 1, 1, 0, 11);         // wake aborts the drain
      for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 1, 0, 11); // must stay RUN
      add(0, 1, 0, 0, 1, 0, 11);
      add(0, 0, 0, 0, 1, 0, 11);
      add(0, 0, 0, 0, 1, 0, 11);
      add(0, 0, 0, 0, 0, 1, 11);         // SLEEP
      // 20 sleeping edges: the count climbs to 15 and then saturates.
      for (int i = 1; i <= 20; i++) begin
         sat = (11 + i > 15) ? 15 : 11 + i;
         add(0, 0, 0, 0, 0, 1, 4'(sat));
      end

      // Reset state.
      #12;
      exp_q.push_back(6'b0);
      check_main("reset_state");
      exp0_q.push_back(10'b0);
      check_zero("reset_state_idle0");
      @(negedge clk);
      rst_n = 1'b1;

      // Apply the vector table.
      for (int i = 0; i < vec_q.size(); i++) begin
         v = vec_q[i];
         step_main(v, $sformatf("vec%0d", i));
      end

      // Asynchronous reset while asleep: outputs must clear without a clock edge.
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      exp_q.push_back(6'b0);
      check_main("async_reset_in_sleep");
      @(posedge clk);
      #1;
      exp_q.push_back(6'b0);
      check_main("reset_held");
      @(negedge clk);
      rst_n = 1'b1;
      v.fe = 0; v.sr = 0; v.bz = 0; v.wk = 0; v.en = 0; v.sl = 0; v.cnt = 0;
      step_main(v, "boot_after_reset");

      // IDLE_CYCLES=0: drain lasts one idle cycle, and busy holds it in DRAIN.
      step_zero(1, 0, 0, 0, 1, 0, 0, "z_run");
      step_zero(0, 1, 0, 0, 1, 0, 0, "z_drain");
      step_zero(0, 0, 1, 0, 1, 0, 0, "z_busy_hold");
      step_zero(0, 0, 0, 0, 0, 1, 0, "z_sleep");
      step_zero(0, 0, 0, 0, 0, 1, 1, "z_sleep_cnt");
      step_zero(0, 0, 0, 1, 1, 0, 2, "z_wake");
      step_zero(0, 1, 0, 0, 1, 0, 2, "z_drain2");
      step_zero(0, 0, 0, 0, 0, 1, 2, "z_one_cycle_drain");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
